// File: rtl/regfile_reader.sv
// Register-file dump engine: streams a wrapped run of registers out over a valid/ready port.
// The read address runs one word ahead of the held beat so back-to-back beats need no bubble.
module regfile_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // READ  | first word being read at addr_q
  // SEND  | beat held on m_*, next word already addressed
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH+1)'(REG_COUNT);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic                    m_last_q, m_last_d;
  logic                    err_q, err_d;
  logic                    load;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_ONE;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_addr_d    = m_addr_q;
    m_last_d    = m_last_q;
    err_d       = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ({1'b0, start_addr_i} < COUNT_MAX) begin
            addr_d      = start_addr_i;
            remaining_d = (count_i == '0 || count_i > COUNT_MAX) ? COUNT_MAX : count_i;
            state_d     = READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READ: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else if (m_ready_i) begin
          if (m_last_q) begin
            state_d   = DONE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // remaining counts words not yet loaded into the output beat
    if (load) begin
      m_data_d    = rdata_i;
      m_addr_d    = addr_q;
      addr_d      = next_addr(addr_q);
      m_valid_d   = 1'b1;
      m_last_d    = (remaining_q == COUNT_ONE);
      remaining_d = remaining_q - COUNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_addr_q    <= '0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_addr_q    <= m_addr_d;
      m_last_q    <= m_last_d;
      err_q       <= err_d;
    end
  end

  assign raddr_o   = addr_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_addr_o  = m_addr_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = (state_q == READ) || (state_q == SEND);
  assign done_o    = (state_q == DONE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: expected beats are queued at start, a monitor pops on each handshake.
// Addresses are 6 bits wide here so an out-of-range start address (40) is representable.
module tb_regfile_reader;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int RC = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [AW:0]   count_i = '0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] raddr_o;
  logic [DW-1:0] rdata_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic          m_last_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  logic [DW-1:0] mem [64];
  assign rdata_i = mem[raddr_o];

  regfile_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .count_i(count_i), .abort_i(abort_i), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_addr_o(m_addr_o), .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem[i] = DW'(i + 1);
  endtask

  task automatic push_dump(input int sa, input int cnt);
    int    n;
    beat_t b;
    n = (cnt == 0 || cnt > RC) ? RC : cnt;
    for (int i = 0; i < n; i++) begin
      b.addr = AW'((sa + i) % RC);
      b.data = DW'(((sa + i) % RC) + 1);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // called just after a rising edge; start_i is sampled on the following edge
  task automatic issue_start(input int sa, input int cnt);
    start_addr_i = AW'(sa);
    count_i      = (AW+1)'(cnt);
    start_i      = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input bit alt, input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, busy_o, 0);
        chk({tag, "_beats_left"}, exp_q.size(), 0);
      end
      @(posedge clk_i); #1;
      if (alt && !seen) begin
        m_ready_i = ~m_ready_i;
        if (m_valid_o && !m_ready_i) mem[m_addr_o] = 32'hDEAD_BEEF;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", tag, budget);
    end else begin
      @(negedge clk_i);
      chk({tag, "_done_one_cycle"}, done_o, 0);
      chk({tag, "_idle_busy"}, busy_o, 0);
    end
    @(posedge clk_i); #1;
  endtask

  // monitor: checks held beats stay stable and scores every accepted beat
  logic          hold_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [AW-1:0] held_addr;
  logic          held_last;

  always @(negedge clk_i) begin
    beat_t e;
    if (rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_data", m_data_o, held_data);
        chk("hold_addr", m_addr_o, held_addr);
        chk("hold_last", m_last_o, held_last);
      end
      if (m_valid_o && m_ready_i && !abort_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: addr %0d data %0h with nothing expected", m_addr_o, m_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", m_addr_o, e.addr);
          chk("beat_data", m_data_o, e.data);
          chk("beat_last", m_last_o, e.last);
        end
      end
      hold_prev = m_valid_o && !m_ready_i && !abort_i;
      held_data = m_data_o;
      held_addr = m_addr_o;
      held_last = m_last_o;
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    init_mem();
    #3;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_raddr", raddr_o, 0);
    chk("rst_mdata", m_data_o, 0);
    chk("rst_maddr", m_addr_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // full dump, continuous ready
    m_ready_i = 1'b1;
    push_dump(0, 0);
    issue_start(0, 0);
    chk("t1_read_busy", busy_o, 1);
    chk("t1_read_novalid", m_valid_o, 0);
    @(posedge clk_i); #1;
    chk("t1_valid_2edges", m_valid_o, 1);
    run_until_done(1'b0, 45, "t1");

    // wrap-around and count clamp
    push_dump(30, 4);
    issue_start(30, 4);
    run_until_done(1'b0, 20, "t2");
    push_dump(3, 50);
    issue_start(3, 50);
    run_until_done(1'b0, 45, "t2b");

    // alternating ready, register writes while stalled
    m_ready_i = 1'b0;
    push_dump(5, 3);
    issue_start(5, 3);
    run_until_done(1'b1, 40, "t3");
    init_mem();
    m_ready_i = 1'b1;

    // rejected start
    issue_start(40, 1);
    chk("t4_err_pulse", err_o, 1);
    chk("t4_err_busy", busy_o, 0);
    chk("t4_err_valid", m_valid_o, 0);
    @(posedge clk_i); #1;
    chk("t4_err_clear", err_o, 0);
    chk("t4_err_valid2", m_valid_o, 0);

    // start during active dump is ignored
    push_dump(10, 4);
    issue_start(10, 4);
    @(posedge clk_i); #1;
    start_addr_i = '0;
    count_i      = 7'd5;
    start_i      = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    run_until_done(1'b0, 20, "t4");
    repeat (5) @(posedge clk_i);
    #1;
    chk("t4_no_extra", m_valid_o, 0);

    // async reset during the third beat of a 10-beat dump
    push_dump(0, 10);
    issue_start(0, 10);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_rst_valid", m_valid_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_beats_before_rst", exp_q.size(), 8);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    push_dump(0, 2);
    issue_start(0, 2);
    chk("t5_restart_busy", busy_o, 1);
    run_until_done(1'b0, 20, "t5");

    // abort on beat 2, simultaneous with ready
    push_dump(0, 8);
    issue_start(0, 8);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    d0 = done_cnt;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("t6_abort_valid", m_valid_o, 0);
    chk("t6_abort_busy", busy_o, 0);
    chk("t6_beats_left", exp_q.size(), 7);
    exp_q.delete();
    repeat (4) @(posedge clk_i);
    #1;
    chk("t6_no_done", done_cnt, d0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH (5, register address width), DATA_WIDTH (32, register data width) and REG_COUNT (32, number of registers, 2..2**ADDR_WIDTH).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  sole clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request a dump; sampled only in IDLE
- start_addr_i  in  ADDR_WIDTH  first register to read
- count_i  in  ADDR_WIDTH+1  registers to read; 0 = REG_COUNT
- abort_i  in  1  terminate an active dump
- raddr_o  out  ADDR_WIDTH  read address to the register file read port
- rdata_i  in  DATA_WIDTH  combinational read data for raddr_o
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream accepts beat
- m_data_o  out  DATA_WIDTH  register contents
- m_addr_o  out  ADDR_WIDTH  address the beat was read from
- m_last_o  out  1  final beat of the dump
- busy_o  out  1  dump in progress
- done_o  out  1  one-cycle pulse on normal completion
- err_o  out  1  one-cycle pulse on a rejected start
REQ-003 The block SHALL use one clock, clk_i, and an asynchronous active-high reset, rst_i.

Function
REQ-004 The FSM SHALL have states IDLE, READ, SEND and DONE; busy_o SHALL be 1 in READ and SEND only.
REQ-005 In IDLE, start_i=1 with start_addr_i<REG_COUNT SHALL latch the address, set remaining = (count_i==0 or count_i>REG_COUNT) ? REG_COUNT : count_i, and move to READ.
REQ-006 In IDLE, start_i=1 with start_addr_i>=REG_COUNT SHALL pulse err_o for one cycle and remain in IDLE with no beats.
REQ-007 start_i SHALL be ignored outside IDLE.
REQ-008 In READ, raddr_o SHALL equal the latched address. At the next edge the block SHALL load m_data_o<=rdata_i and m_addr_o<=address, assert m_valid_o, set m_last_o=(remaining==1), and enter SEND.
REQ-009 In SEND, raddr_o SHALL present the address following m_addr_o, so rdata_i always holds the next word.
REQ-010 A handshake (m_valid_o & m_ready_i) in SEND with m_last_o=0 SHALL load the next word, address and m_last_o, and decrement remaining. m_valid_o SHALL stay 1, giving one beat per cycle under continuous ready.
REQ-011 A handshake with m_last_o=1 SHALL clear m_valid_o and move to DONE.
REQ-012 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-013 Addresses SHALL increment modulo REG_COUNT: REG_COUNT-1 wraps to 0.
REQ-014 While m_valid_o=1 and m_ready_i=0, m_data_o, m_addr_o and m_last_o SHALL hold stable, and a register-file write SHALL NOT alter the held beat.
REQ-015 abort_i=1 in READ or SEND SHALL return the FSM to IDLE at the next edge with m_valid_o=0 and without pulsing done_o. abort_i SHALL take priority over a simultaneous handshake.
REQ-016 A dump SHALL produce exactly remaining beats, read from consecutive wrapped addresses.

Reset
REQ-017 rst_i=1 SHALL immediately, independent of clk_i, force state IDLE and set m_valid_o, m_last_o, busy_o, done_o and err_o to 0, and m_data_o, m_addr_o, raddr_o and the internal counters to 0.
REQ-018 Reset asserted mid-dump SHALL discard the dump. After deassertion the block SHALL accept a new start_i on the first rising edge.

Verification (register file preloaded with reg[i]=i+1, REG_COUNT=32)
REQ-019 start_addr=0, count=0, m_ready_i held 1 -> m_valid_o rises 2 edges after start. 32 consecutive beats follow with m_addr 0..31 and m_data 1..32; m_last_o is set on the beat with m_addr 31 only; done_o pulses one cycle later; busy_o then falls.
REQ-020 start_addr=30, count=4 -> beats with m_addr 30,31,0,1 and m_data 31,32,1,2; m_last_o is set on the beat with m_addr 1.
REQ-021 start_addr=5, count=3, m_ready_i alternating 0/1 -> each beat (data 6,7,8) is held stable until accepted, and no beat is lost or duplicated.
REQ-022 start_addr=40 -> err_o pulses one cycle; busy_o and m_valid_o stay 0. A start_i pulse during an active dump -> ignored; the beat count is unchanged.
REQ-023 rst_i asserted between clock edges during beat 3 of a 10-beat dump -> m_valid_o and busy_o go 0 before the next edge. A subsequent start_addr=0, count=2 dump yields data 1,2.
REQ-024 abort_i pulsed on beat 2 of an 8-beat dump -> m_valid_o=0 and busy_o=0 after the next edge; done_o never pulses.
